// File: rtl/io_input_port.sv
// Debounced switch/button input port with sticky button-press flags and a press counter.
// Processor-visible registers: 0 switches, 1 buttons, 2 press flags (RC/W1C), 3 press count.
module io_input_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [7:0]  SW,
  input  logic [3:0]  BTN,
  input  logic [3:0]  IOAddr,
  input  logic        IOReadEn,
  input  logic        IOWriteEn,
  input  logic [31:0] IOWriteData,
  output logic [31:0] IOReadData
);

  localparam int          NB = 12;
  localparam logic [15:0] TC = 16'(DEBOUNCE_CYCLES - 1);

  logic [NB-1:0] sync_1, sync_2, level, level_nxt;
  logic [15:0]   db_count     [NB];
  logic [15:0]   db_count_nxt [NB];
  logic [3:0]    btn_event, btn_rise, ev_clear;
  logic [15:0]   event_count;
  logic [2:0]    rise_cnt;
  logic          unused_wdata;

  assign unused_wdata = ^IOWriteData[31:4];

  // Buttons occupy bits 11:8 so one debouncer loop covers every input.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= {BTN, SW};
      sync_2 <= sync_1;
    end
  end

  always_comb begin
    level_nxt = level;
    for (int i = 0; i < NB; i++) begin
      db_count_nxt[i] = '0;
      if (sync_2[i] != level[i]) begin
        if (db_count[i] == TC) level_nxt[i] = sync_2[i];
        else                   db_count_nxt[i] = db_count[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      level <= '0;
      for (int i = 0; i < NB; i++) db_count[i] <= '0;
    end else begin
      level <= level_nxt;
      for (int i = 0; i < NB; i++) db_count[i] <= db_count_nxt[i];
    end
  end

  assign btn_rise = level_nxt[11:8] & ~level[11:8];
  assign rise_cnt = {2'b0, btn_rise[0]} + {2'b0, btn_rise[1]} +
                    {2'b0, btn_rise[2]} + {2'b0, btn_rise[3]};

  // Read clears only flags visible this cycle; a same-cycle rise still wins.
  always_comb begin
    ev_clear = '0;
    if (IOReadEn  && IOAddr == 4'd2) ev_clear = ev_clear | btn_event;
    if (IOWriteEn && IOAddr == 4'd2) ev_clear = ev_clear | IOWriteData[3:0];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      btn_event   <= '0;
      event_count <= '0;
    end else begin
      btn_event <= (btn_event & ~ev_clear) | btn_rise;
      if (IOWriteEn && IOAddr == 4'd3) event_count <= {13'b0, rise_cnt};
      else                             event_count <= event_count + {13'b0, rise_cnt};
    end
  end

  always_comb begin
    IOReadData = '0;
    case (IOAddr)
      4'd0:    IOReadData = {24'b0, level[7:0]};
      4'd1:    IOReadData = {28'b0, level[11:8]};
      4'd2:    IOReadData = {28'b0, btn_event};
      4'd3:    IOReadData = {16'b0, event_count};
      default: IOReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_io_input_port.sv
// Bench for io_input_port: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a run-length behavioural model.
module tb_io_input_port;
  localparam int N = 4;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [7:0]  SW;
  logic [3:0]  BTN;
  logic [3:0]  IOAddr;
  logic        IOReadEn, IOWriteEn;
  logic [31:0] IOWriteData;
  logic [31:0] IOReadData;

  int total = 0;
  int bad   = 0;

  // model: raw inputs reach the debouncer two edges late; a level flips after
  // N consecutive edges of disagreement.
  logic [11:0] m_d1 = '0, m_d2 = '0, m_lvl = '0;
  int          m_run [12];
  logic [3:0]  m_ev = '0;
  logic [15:0] m_cnt = '0;

  io_input_port #(.DEBOUNCE_CYCLES(N)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SW(SW), .BTN(BTN), .IOAddr(IOAddr),
    .IOReadEn(IOReadEn), .IOWriteEn(IOWriteEn), .IOWriteData(IOWriteData),
    .IOReadData(IOReadData)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a)
      4'd0:    return {24'b0, m_lvl[7:0]};
      4'd1:    return {28'b0, m_lvl[11:8]};
      4'd2:    return {28'b0, m_ev};
      4'd3:    return {16'b0, m_cnt};
      default: return 32'b0;
    endcase
  endfunction

  task automatic model_step();
    logic [11:0] old_lvl;
    logic [3:0]  rise, clr;
    int          presses;
    if (!RESET_N) begin
      m_d1 = '0; m_d2 = '0; m_lvl = '0; m_ev = '0; m_cnt = '0;
      for (int i = 0; i < 12; i++) m_run[i] = 0;
    end else begin
      old_lvl = m_lvl;
      for (int i = 0; i < 12; i++) begin
        if (m_d2[i] != m_lvl[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == N) begin
            m_lvl[i] = m_d2[i];
            m_run[i] = 0;
          end
        end else m_run[i] = 0;
      end
      rise = m_lvl[11:8] & ~old_lvl[11:8];
      presses = 0;
      for (int i = 0; i < 4; i++) if (rise[i]) presses++;
      clr = '0;
      if (IOReadEn  && IOAddr == 4'd2) clr = clr | m_ev;
      if (IOWriteEn && IOAddr == 4'd2) clr = clr | IOWriteData[3:0];
      m_ev = (m_ev & ~clr) | rise;
      if (IOWriteEn && IOAddr == 4'd3) m_cnt = 16'(presses);
      else                             m_cnt = m_cnt + 16'(presses);
      m_d2 = m_d1;
      m_d1 = {BTN, SW};
    end
  endtask

  initial begin
    for (int i = 0; i < 12; i++) m_run[i] = 0;
    forever begin
      @(posedge CLK);
      model_step();
      #2 check("model_read", IOReadData, m_read(IOAddr));
    end
  end

  task automatic rd_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    IOAddr = a;
    #1 check(name, IOReadData, exp);
  endtask

  task automatic press(input logic [3:0] b);
    @(negedge CLK) BTN = b;
    repeat (10) @(negedge CLK);
    BTN = 4'b0;
    repeat (10) @(negedge CLK);
  endtask

  initial begin
    RESET_N = 1'b0; SW = '0; BTN = '0; IOAddr = '0;
    IOReadEn = 1'b0; IOWriteEn = 1'b0; IOWriteData = '0;
    for (int a = 0; a < 16; a++) rd_check("reset_read", 4'(a), 32'h0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK);

    // switches appear exactly N+2 edges after they change
    @(negedge CLK) begin SW = 8'hA5; IOAddr = 4'd0; end
    repeat (5) @(posedge CLK);
    #2 check("sw_edge5", IOReadData, 32'h0);
    @(posedge CLK);
    #2 check("sw_edge6", IOReadData, 32'hA5);

    // 3-cycle glitch never reaches the level
    @(negedge CLK) BTN = 4'b0001;
    repeat (3) @(negedge CLK);
    BTN = 4'b0;
    repeat (10) @(negedge CLK);
    rd_check("glitch_db", 4'd1, 32'h0);
    rd_check("glitch_ev", 4'd2, 32'h0);
    rd_check("glitch_cnt", 4'd3, 32'h0);

    press(4'b0100);
    rd_check("btn2_ev", 4'd2, 32'h4);
    rd_check("btn2_cnt", 4'd3, 32'h1);
    @(negedge CLK) begin IOAddr = 4'd2; IOReadEn = 1'b1; end
    @(negedge CLK) IOReadEn = 1'b0;
    rd_check("rtc_cleared", 4'd2, 32'h0);

    press(4'b0011);
    rd_check("dual_cnt", 4'd3, 32'h3);
    rd_check("dual_ev", 4'd2, 32'h3);

    // BTN[3] debounced rise lands on the same edge as a read-to-clear
    @(negedge CLK) BTN = 4'b1000;
    repeat (5) @(negedge CLK);
    IOReadEn = 1'b1;
    rd_check("pre_rtc", 4'd2, 32'h3);
    @(negedge CLK) IOReadEn = 1'b0;
    rd_check("set_wins", 4'd2, 32'h8);
    @(negedge CLK) BTN = 4'b0;
    repeat (10) @(negedge CLK);

    // count wrap from all-ones, then write-load
    @(negedge CLK) begin force dut.event_count = 16'hFFFF; m_cnt = 16'hFFFF; end
    @(negedge CLK) release dut.event_count;
    rd_check("forced_cnt", 4'd3, 32'hFFFF);
    press(4'b0001);
    rd_check("wrap_cnt", 4'd3, 32'h0);
    press(4'b0001);
    rd_check("after_wrap", 4'd3, 32'h1);
    @(negedge CLK) begin IOAddr = 4'd3; IOWriteEn = 1'b1; IOWriteData = 32'hFFFF_FFFF; end
    @(negedge CLK) IOWriteEn = 1'b0;
    rd_check("wr_cnt", 4'd3, 32'h0);
    rd_check("ev_before_w1c", 4'd2, 32'h9);
    @(negedge CLK) begin IOAddr = 4'd2; IOWriteEn = 1'b1; IOWriteData = 32'h1; end
    @(negedge CLK) IOWriteEn = 1'b0;
    rd_check("w1c", 4'd2, 32'h8);
    @(negedge CLK) begin IOAddr = 4'd5; IOWriteEn = 1'b1; IOWriteData = 32'hF; end
    @(negedge CLK) IOWriteEn = 1'b0;
    rd_check("wr_ignored", 4'd2, 32'h8);

    // reset mid-debounce; held button debounces to a fresh event afterwards
    @(negedge CLK) begin SW = 8'hFF; IOAddr = 4'd0; end
    repeat (3) @(negedge CLK);
    RESET_N = 1'b0; BTN = 4'b0010;
    for (int a = 0; a < 4; a++) rd_check("mid_reset", 4'(a), 32'h0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1; IOAddr = 4'd0;
    repeat (5) @(posedge CLK);
    #2 check("rst_sw_edge5", IOReadData, 32'h0);
    @(posedge CLK);
    #2 check("rst_sw_edge6", IOReadData, 32'hFF);
    @(negedge CLK);
    rd_check("rel_ev", 4'd2, 32'h2);
    rd_check("rel_cnt", 4'd3, 32'h1);
    @(negedge CLK) BTN = 4'b0;
    repeat (10) @(negedge CLK);

    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if ($urandom_range(0, 5) == 0) BTN[$urandom_range(0, 3)] = ~BTN[$urandom_range(0, 3)];
      if ($urandom_range(0, 19) == 0) SW = 8'($urandom);
      IOAddr = ($urandom_range(0, 5) < 4) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
      IOReadEn    = ($urandom_range(0, 3) == 0);
      IOWriteEn   = ($urandom_range(0, 5) == 0);
      IOWriteData = $urandom;
      if (c == 1500) RESET_N = 1'b0;
      if (c == 1503) RESET_N = 1'b1;
    end
    @(negedge CLK) begin IOReadEn = 1'b0; IOWriteEn = 1'b0; end
    repeat (2) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
